// File: rtl/eth_unpacker.sv
// eth_unpacker: RMII receive unpacker that locks on preamble/SFD, filters broadcast,
// captures length, streams the payload as dibits and checks the trailing CRC-32 FCS.
module eth_unpacker #(
    parameter int MIN_PRE_DIBITS = 8,
    parameter int ADDR_DIBITS    = 24,
    parameter int LEN_DIBITS     = 8,
    parameter int PAYLOAD_DIBITS = 1280,
    parameter int CRC_DIBITS     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic        axiov,
    output logic [1:0]  axiod,
    output logic [15:0] len_field,
    output logic        eof,
    output logic        fcs_ok,
    output logic        frame_err
);
    localparam int CW = $clog2(PAYLOAD_DIBITS + 1);
    localparam logic [CW-1:0] PRE_MIN = CW'(MIN_PRE_DIBITS);
    localparam logic [CW-1:0] A_LAST  = CW'(ADDR_DIBITS - 1);
    localparam logic [CW-1:0] L_LAST  = CW'(LEN_DIBITS - 1);
    localparam logic [CW-1:0] P_LAST  = CW'(PAYLOAD_DIBITS - 1);
    localparam logic [CW-1:0] C_LAST  = CW'(CRC_DIBITS - 1);

    localparam logic [3:0] IDLE = 4'd0, PRE = 4'd1, DEST = 4'd2, SRC = 4'd3, LEN = 4'd4,
                           DATA = 4'd5, FCS = 4'd6, DONE = 4'd7, DROP = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   len_q, len_d;
    logic [31:0]   rx_fcs_q, rx_fcs_d;
    logic [1:0]    axiod_q, axiod_d;
    logic          axiov_q, axiov_d, eof_q, eof_d, fcs_ok_q, fcs_ok_d, frame_err_q, frame_err_d;
    logic          crc_rst_q, crc_rst_d;
    logic [31:0]   crc_out;
    logic          crc_en;

    assign crc_en = crsdv && (state_q inside {DEST, SRC, LEN, DATA});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        len_d       = len_q;
        rx_fcs_d    = rx_fcs_q;
        axiov_d     = 1'b0;
        axiod_d     = axiod_q;
        eof_d       = 1'b0;
        fcs_ok_d    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (crsdv && rxd == 2'b01) begin
                    state_d = PRE;
                    cnt_d   = CW'(1);
                end
            end
            PRE: begin
                if (crsdv && rxd == 2'b01) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                else begin
                    state_d = (crsdv && rxd == 2'b11 && cnt_q >= PRE_MIN) ? DEST : DROP;
                    cnt_d   = '0;
                end
            end
            DEST: begin
                if (!crsdv || rxd != 2'b11) begin
                    state_d = DROP;
                    cnt_d   = '0;
                end else if (cnt_q == A_LAST) begin
                    state_d = SRC;
                    cnt_d   = '0;
                end
            end
            SRC: begin
                if (cnt_q == A_LAST) begin
                    state_d = LEN;
                    cnt_d   = '0;
                end
            end
            LEN: begin
                len_d = {len_q[13:0], rxd};
                if (cnt_q == L_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                axiov_d = 1'b1;
                axiod_d = rxd;
                if (cnt_q == P_LAST) begin
                    state_d = FCS;
                    cnt_d   = '0;
                end
            end
            FCS: begin
                // wire order puts the first bit of each dibit at the higher FCS index
                rx_fcs_d = {rx_fcs_q[29:0], rxd[0], rxd[1]};
                if (cnt_q == C_LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    eof_d    = 1'b1;
                    fcs_ok_d = (rx_fcs_d == crc_out);
                end
            end
            DONE: begin
                state_d = crsdv ? DROP : IDLE;
                cnt_d   = '0;
            end
            DROP: begin
                cnt_d   = '0;
                state_d = crsdv ? DROP : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!crsdv && (state_q inside {SRC, LEN, DATA, FCS})) begin
            state_d     = IDLE;
            cnt_d       = '0;
            len_d       = len_q;
            rx_fcs_d    = rx_fcs_q;
            axiov_d     = 1'b0;
            axiod_d     = axiod_q;
            eof_d       = 1'b1;
            fcs_ok_d    = 1'b0;
            frame_err_d = 1'b1;
        end
        crc_rst_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            rx_fcs_q    <= '0;
            axiov_q     <= 1'b0;
            axiod_q     <= '0;
            eof_q       <= 1'b0;
            fcs_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            crc_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            rx_fcs_q    <= rx_fcs_d;
            axiov_q     <= axiov_d;
            axiod_q     <= axiod_d;
            eof_q       <= eof_d;
            fcs_ok_q    <= fcs_ok_d;
            frame_err_q <= frame_err_d;
            crc_rst_q   <= crc_rst_d;
        end
    end

    // registered reset keeps the CRC's async clear glitch-free while covering Idle and rst
    crc32 u_crc (
        .clk   (clk),
        .rst   (crc_rst_q),
        .axiiv (crc_en),
        .axiid (rxd),
        .axiod (crc_out)
    );

    assign axiov     = axiov_q;
    assign axiod     = axiod_q;
    assign len_field = len_q;
    assign eof       = eof_q;
    assign fcs_ok    = fcs_ok_q;
    assign frame_err = frame_err_q;
endmodule

// crc32: Ethernet CRC-32 over a dibit stream, axiid[0] first; axiod is the complemented remainder.
module crc32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic [31:0] axiod
);
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    logic [31:0] crc_q, crc_d, c1;

    always_comb begin
        c1    = {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ axiid[0]) ? POLY : 32'h0);
        crc_d = {c1[30:0], 1'b0} ^ ((c1[31] ^ axiid[1]) ? POLY : 32'h0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '1;
        else if (axiiv) crc_q <= crc_d;
    end

    assign axiod = ~crc_q;
endmodule

// File: tb/tb_eth_unpacker.sv
// tb_eth_unpacker: directed RMII frames; expected payload and eof status are queued by the
// driver and checked by an independent monitor.
module tb_eth_unpacker;
    logic        clk = 1'b0, rst = 1'b1, crsdv = 1'b0;
    logic [1:0]  rxd = 2'b00;
    logic        axiov, eof, fcs_ok, frame_err;
    logic [1:0]  axiod;
    logic [15:0] len_field;

    int total = 0, bad = 0;
    logic [1:0]  exp_data[$];
    logic [1:0]  exp_eof[$];
    logic [31:0] crc_m;
    logic [15:0] exp_len = 16'h0;

    eth_unpacker dut (
        .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd), .axiov(axiov), .axiod(axiod),
        .len_field(len_field), .eof(eof), .fcs_ok(fcs_ok), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C1_1DB7 : 32'h0);
    endfunction

    task automatic feed(input logic [1:0] d);
        crc_m = crc_bit(crc_bit(crc_m, d[0]), d[1]);
    endtask

    task automatic send(input logic c, input logic [1:0] d);
        @(posedge clk);
        #1;
        crsdv = c;
        rxd   = d;
    endtask

    always @(negedge clk) begin
        if (axiov) begin
            if (exp_data.size() == 0) begin
                total++;
                bad++;
                $display("FAIL axiov_extra actual axiov=1 axiod=%b required no pending payload", axiod);
            end else check("axiod", {30'b0, axiod}, {30'b0, exp_data.pop_front()});
        end
        if (eof) begin
            if (exp_eof.size() == 0) begin
                total++;
                bad++;
                $display("FAIL eof_extra actual eof=1 fcs_ok=%b frame_err=%b required no eof", fcs_ok, frame_err);
            end else check("eof_status{fcs_ok,frame_err}", {30'b0, fcs_ok, frame_err}, {30'b0, exp_eof.pop_front()});
        end
    end

    task automatic frame(input int npre, input int bad_dest, input logic [15:0] len,
                         input int ndata, input int flip_idx, input int rst_idx);
        logic [1:0]  d;
        logic [31:0] fcs;
        bit valid, done;
        valid = (npre >= 8) && (bad_dest < 0);
        done  = 0;
        crc_m = '1;
        for (int i = 0; i < npre; i++) send(1'b1, 2'b01);
        send(1'b1, 2'b11);
        for (int i = 0; i < 24; i++) begin
            d = (i == bad_dest) ? 2'b10 : 2'b11;
            feed(d);
            send(1'b1, d);
        end
        for (int i = 0; i < 24; i++) begin
            feed(2'b10);
            send(1'b1, 2'b10);
        end
        for (int i = 0; i < 8; i++) begin
            d = len[15-2*i -: 2];
            feed(d);
            send(1'b1, d);
        end
        if (valid) exp_len = len;
        for (int i = 0; i < 1280 && !done; i++) begin
            if (i == ndata) begin
                if (valid) exp_eof.push_back(2'b01);
                send(1'b0, 2'b00);
                done = 1;
            end else begin
                d = i[1:0];
                feed(d);
                if (i == flip_idx) d = d ^ 2'b01;
                if (valid) exp_data.push_back(d);
                send(1'b1, d);
                if (i == rst_idx) begin
                    #2;
                    check("axiov_before_rst", {31'b0, axiov}, 32'd1);
                    rst = 1'b1;
                    #1;
                    check("axiov_async_rst", {31'b0, axiov}, 32'd0);
                    check("len_async_rst", {16'b0, len_field}, 32'd0);
                    exp_data.delete();
                    exp_eof.delete();
                    exp_len = 16'h0;
                    @(posedge clk);
                    #1;
                    rst   = 1'b0;
                    crsdv = 1'b0;
                    rxd   = 2'b00;
                    done  = 1;
                end
            end
        end
        if (!done) begin
            fcs = ~crc_m;
            for (int k = 0; k < 16; k++) send(1'b1, {fcs[30-2*k], fcs[31-2*k]});
            if (valid) exp_eof.push_back({flip_idx < 0, 1'b0});
            send(1'b0, 2'b00);
        end
        repeat (4) send(1'b0, 2'b00);
        check("payload_left", exp_data.size(), 32'd0);
        check("eof_left", exp_eof.size(), 32'd0);
        check("len_field", {16'b0, len_field}, {16'b0, exp_len});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_axiov", {31'b0, axiov}, 32'd0);
        check("rst_axiod", {30'b0, axiod}, 32'd0);
        check("rst_len", {16'b0, len_field}, 32'd0);
        check("rst_eof", {31'b0, eof}, 32'd0);
        check("rst_fcs_ok", {31'b0, fcs_ok}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        rst = 1'b0;
        frame(31, -1, 16'hABCD, 1280, -1, -1);
        frame(31, -1, 16'h1357, 1280, 100, -1);
        frame(31, 12, 16'h2222, 1280, -1, -1);
        frame(31, -1, 16'h0F0F, 1280, -1, -1);
        frame(4, -1, 16'h3333, 1280, -1, -1);
        frame(7, -1, 16'h4444, 1280, -1, -1);
        frame(8, -1, 16'h8001, 1280, -1, -1);
        frame(31, -1, 16'h4242, 600, -1, -1);
        frame(31, -1, 16'h5AA5, 1280, -1, -1);
        frame(31, -1, 16'h6666, 1280, -1, 300);
        frame(31, -1, 16'hBEEF, 1280, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
